// File: rtl/logic_unit_pipe_pkg.sv
// Purpose: shared opcode width and opcode constants for the pipelined logic unit.
// Ports:   none (package).
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'b000;
  localparam logic [OP_W-1:0] OP_OR   = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b011;
  localparam logic [OP_W-1:0] OP_MUX  = 3'b100;
  localparam logic [OP_W-1:0] OP_DMUX = 3'b101;
  localparam logic [OP_W-1:0] OP_PASS = 3'b110;
  localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Purpose: bundles the input/output handshakes, operands, accumulator clear
//          and observed accumulator of the logic unit.
// Ports:   master = producer/consumer side (drives in_valid, op, use_acc, a, b,
//          acc_clr, out_ready); slave = the logic unit (drives in_ready,
//          out_valid, result, zero, err, acc).
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
);
  import logic_unit_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic            use_acc;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic            acc_clr;
  logic            out_valid;
  logic            out_ready;
  logic [WIDTH-1:0] result;
  logic            zero;
  logic            err;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, op, use_acc, a, b, acc_clr, out_ready,
    input  in_ready, out_valid, result, zero, err, acc
  );

  modport slave (
    input  in_valid, op, use_acc, a, b, acc_clr, out_ready,
    output in_ready, out_valid, result, zero, err, acc
  );

endinterface

// File: rtl/logic_unit_pipe_core.sv
// Purpose: combinational opcode-selected logic function.
// Ports:   op_i (opcode), a_i (effective operand A), b_i (operand b) ->
//          result_o, zero_o (result is all zeros), err_o (reserved opcode).
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o
);

  localparam int SEL_W = $clog2(WIDTH);

  logic [SEL_W-1:0] sel;

  assign sel = b_i[SEL_W-1:0];

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOT:  result_o = ~a_i;
      OP_MUX:  result_o[0] = a_i[sel];
      OP_DMUX: result_o = WIDTH'(a_i[0]) << sel;
      OP_PASS: result_o = b_i;
      default: err_o = 1'b1;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/logic_unit_pipe.sv
// Purpose: two-stage pipelined logic unit with valid/ready handshakes and an
//          accumulator that can stand in for operand a.
// Ports:   clk, rst (async, active-high); bus (slave modport) carrying the
//          input handshake + operands, acc_clr, output handshake + result,
//          zero, err flags and the accumulator value.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  logic_unit_pipe_if.slave bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [OP_W-1:0]  s1_op_q, s1_op_d;
  logic             s1_use_acc_q, s1_use_acc_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             adv2;
  logic             in_xfer;
  logic [WIDTH-1:0] eff_a;
  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_err;

  assign adv2    = s1_valid_q && (!s2_valid_q || bus.out_ready);
  assign bus.in_ready = !rst && (!s1_valid_q || adv2);
  assign in_xfer = bus.in_valid && bus.in_ready;

  // acc_q is the pre-edge value, so chained use_acc transactions see the
  // previous result and an acc_clr in the same cycle does not affect them.
  assign eff_a = s1_use_acc_q ? acc_q : s1_a_q;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op_i     (s1_op_q),
    .a_i      (eff_a),
    .b_i      (s1_b_q),
    .result_o (core_result),
    .zero_o   (core_zero),
    .err_o    (core_err)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_op_d      = s1_op_q;
    s1_use_acc_d = s1_use_acc_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    if (in_xfer) begin
      s1_valid_d   = 1'b1;
      s1_op_d      = bus.op;
      s1_use_acc_d = bus.use_acc;
      s1_a_d       = bus.a;
      s1_b_d       = bus.b;
    end else if (adv2) begin
      s1_valid_d = 1'b0;
    end

    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    err_d      = err_q;
    if (adv2) begin
      s2_valid_d = 1'b1;
      result_d   = core_result;
      zero_d     = core_zero;
      err_d      = core_err;
    end else if (bus.out_ready) begin
      s2_valid_d = 1'b0;
    end

    // Clear beats the write-back of a transaction leaving S1 this cycle.
    acc_d = acc_q;
    if (bus.acc_clr) begin
      acc_d = '0;
    end else if (adv2 && !core_err) begin
      acc_d = core_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_use_acc_q <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s2_valid_q   <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_use_acc_q <= s1_use_acc_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s2_valid_q   <= s2_valid_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      err_q        <= err_d;
      acc_q        <= acc_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Testbench for logic_unit_pipe: directed stimulus with a result scoreboard
// for the WIDTH=8 instance, plus a short WIDTH=16 MUX check.
module tb_logic_unit_pipe;

  logic clk;
  logic rst;

  logic_unit_pipe_if #(.WIDTH(8))  bus ();
  logic_unit_pipe_if #(.WIDTH(16)) bus16 ();

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic_unit_pipe #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int popped = 0;
  logic [7:0] model_acc = 8'h00;
  logic [9:0] sb_q[$];   // {result, zero, err}

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv);
    logic [2:0] s;
    s = bv[2:0];
    case (op)
      3'd0: return av & bv;
      3'd1: return av | bv;
      3'd2: return av ^ bv;
      3'd3: return ~av;
      3'd4: return (av >> s) & 8'h01;
      3'd5: return av[0] ? (8'h01 << s) : 8'h00;
      3'd6: return bv;
      default: return 8'h00;
    endcase
  endfunction

  // Scoreboard consumer: an output transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_output", {6'd0, bus.result, bus.zero, bus.err}, 16'hFFFF);
      end else begin
        logic [9:0] e;
        e = sb_q.pop_front();
        popped++;
        chk("result", {8'd0, bus.result}, {8'd0, e[9:2]});
        chk("zero", {15'd0, bus.zero}, {15'd0, e[1]});
        chk("err", {15'd0, bus.err}, {15'd0, e[0]});
      end
    end
  end

  // Drive a transaction starting #1 after a rising edge; returns #1 after
  // the accepting edge.
  task automatic send(input logic [2:0] op_v, input logic ua, input logic [7:0] av, input logic [7:0] bv);
    logic [7:0] ea;
    logic [7:0] r;
    logic done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = op_v;
    bus.use_acc  = ua;
    bus.a        = av;
    bus.b        = bv;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ea = ua ? model_acc : av;
        r  = model(op_v, ea, bv);
        sb_q.push_back({r, (r == 8'h00), (op_v == 3'd7)});
        if (op_v != 3'd7) model_acc = r;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("accept_timeout", {15'd0, done}, 16'd1);
  endtask

  task automatic wait_drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0 && !bus.out_valid) ok = 1'b1;
    end
    chk("drain_timeout", {15'd0, ok}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] held;
    int base;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = 3'd0; bus.use_acc = 1'b0;
    bus.a = 8'h00; bus.b = 8'h00; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.op = 3'd0; bus16.use_acc = 1'b0;
    bus16.a = 16'h0000; bus16.b = 16'h0000; bus16.acc_clr = 1'b0; bus16.out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
    chk("rst_result", {8'd0, bus.result}, 16'd0);
    chk("rst_acc", {8'd0, bus.acc}, 16'd0);
    chk("rst_zero_err", {14'd0, bus.zero, bus.err}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: AND with latency and accumulator
    send(3'd0, 1'b0, 8'hF0, 8'h3C);
    chk("t1_not_yet_valid", {15'd0, bus.out_valid}, 16'd0);
    @(posedge clk);
    #1;
    chk("t1_valid_latency", {15'd0, bus.out_valid}, 16'd1);
    chk("t1_result", {8'd0, bus.result}, 16'h0030);
    chk("t1_acc", {8'd0, bus.acc}, 16'h0030);
    wait_drain();

    // 2: MUX / DMUX boundaries
    send(3'd4, 1'b0, 8'h80, 8'h07);
    send(3'd5, 1'b0, 8'h01, 8'h05);
    send(3'd5, 1'b0, 8'h00, 8'h05);
    wait_drain();

    // 3: back-to-back accumulator chaining
    send(3'd6, 1'b0, 8'h00, 8'h0F);
    send(3'd2, 1'b1, 8'h00, 8'hFF);
    send(3'd1, 1'b1, 8'h00, 8'h01);
    wait_drain();
    chk("t3_acc", {8'd0, bus.acc}, 16'h00F1);

    // 4: stall with 4 offered transactions
    base = popped;
    bus.out_ready = 1'b0;
    send(3'd6, 1'b0, 8'h00, 8'hA1);
    send(3'd6, 1'b0, 8'h00, 8'hA2);
    bus.in_valid = 1'b1; bus.op = 3'd6; bus.b = 8'hA3;
    @(negedge clk);
    held = bus.result;
    chk("t4_held_first", {8'd0, held}, 16'h00A1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_in_ready_low", {15'd0, bus.in_ready}, 16'd0);
      chk("t4_result_stable", {8'd0, bus.result}, {8'd0, held});
      chk("t4_out_valid_held", {15'd0, bus.out_valid}, 16'd1);
    end
    chk("t4_accepted", sb_q.size()[15:0], 16'd2);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(3'd6, 1'b0, 8'h00, 8'hA3);
    send(3'd6, 1'b0, 8'h00, 8'hA4);
    wait_drain();
    chk("t4_emerged", 16'(popped - base), 16'd4);

    // 5: reserved opcode and acc_clr priority
    send(3'd6, 1'b0, 8'h00, 8'h55);
    send(3'd7, 1'b1, 8'h12, 8'h34);
    wait_drain();
    chk("t5_acc_kept", {8'd0, bus.acc}, 16'h0055);
    bus.acc_clr = 1'b1;
    send(3'd6, 1'b0, 8'h00, 8'h77);
    @(posedge clk);
    #1;
    bus.acc_clr = 1'b0;
    model_acc = 8'h00;
    chk("t5_clr_result", {8'd0, bus.result}, 16'h0077);
    chk("t5_clr_acc", {8'd0, bus.acc}, 16'h0000);
    wait_drain();

    // 6: asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    send(3'd6, 1'b0, 8'h00, 8'h5A);
    send(3'd6, 1'b0, 8'h00, 8'hC3);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("t6_acc", {8'd0, bus.acc}, 16'd0);
    chk("t6_result", {8'd0, bus.result}, 16'd0);
    chk("t6_in_ready", {15'd0, bus.in_ready}, 16'd0);
    sb_q.delete();
    model_acc = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(3'd0, 1'b0, 8'hFF, 8'h0F);
    chk("t6_not_yet_valid", {15'd0, bus.out_valid}, 16'd0);
    @(posedge clk);
    #1;
    chk("t6_valid_latency", {15'd0, bus.out_valid}, 16'd1);
    chk("t6_result_after", {8'd0, bus.result}, 16'h000F);
    wait_drain();

    // WIDTH=16 MUX top bit
    chk("w16_in_ready", {15'd0, bus16.in_ready}, 16'd1);
    bus16.in_valid = 1'b1; bus16.op = 3'd4; bus16.a = 16'h8000; bus16.b = 16'h000F;
    @(posedge clk);
    #1;
    bus16.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("w16_valid", {15'd0, bus16.out_valid}, 16'd1);
    chk("w16_mux", bus16.result, 16'h0001);
    chk("w16_acc", bus16.acc, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
